// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Grant identifiers (one bit: fetch or data)
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // All-ones byte enable pattern; sliced to DW/8 bits by the user
  localparam logic [63:0] BE_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - saturating wait-state counter with expiry flag
module arb_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] count;

  // Count wait cycles; clear has priority, hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for the unified memory port
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            timeout_err
);

  import mem_arb_pkg::*;

  localparam int BW = DW / 8;

  arb_state_t state;
  arb_state_t next_state;
  logic       gnt;
  logic       next_gnt;
  logic       last_grant;
  logic       start;
  logic       other_req;
  logic       aborted;
  logic       expired;
  logic       done;

  // Requester that was not just served; the served one is masked in RESP
  assign other_req = (gnt == GNT_IF) ? d_req : if_req;
  assign done      = (state == ACCESS) && (mem_ready || expired);

  arb_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .en     ((state == ACCESS) && !mem_ready),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, grant selection and access-start decode
  always_comb begin
    next_state = state;
    next_gnt   = gnt;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          start      = 1'b1;
          next_state = ACCESS;
          if (if_req && d_req) begin
            next_gnt = (last_grant == GNT_D) ? GNT_IF : GNT_D;
          end else begin
            next_gnt = if_req ? GNT_IF : GNT_D;
          end
        end
      end
      ACCESS: begin
        if (mem_ready || expired) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (other_req) begin
          start      = 1'b1;
          next_state = ACCESS;
          next_gnt   = ~gnt;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant, memory-side request registers and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= GNT_IF;
      last_grant <= GNT_D;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      aborted    <= 1'b0;
    end else begin
      if (start) begin
        gnt <= next_gnt;
        if (next_gnt == GNT_IF) begin
          mem_addr  <= if_addr;
          mem_we    <= 1'b0;
          mem_be    <= BE_ALL[BW-1:0];
          mem_wdata <= '0;
        end else begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_wdata <= d_wdata;
        end
      end
      if (done) begin
        aborted <= !mem_ready;
        if (gnt == GNT_IF) begin
          if_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          d_rdata <= mem_ready ? mem_rdata : '0;
        end
      end
      if (state == RESP) begin
        last_grant <= gnt;
      end
    end
  end

  assign mem_en      = (state == ACCESS);
  assign busy        = (state != IDLE);
  assign if_ack      = (state == RESP) && (gnt == GNT_IF);
  assign d_ack       = (state == RESP) && (gnt == GNT_D);
  assign timeout_err = (state == RESP) && aborted;

endmodule
